// File: rtl/victim_wb_pkg.sv
// Shared types and helpers for the victim-cache writeback buffer.
// Optional feature macro used by victim_wb_buffer: VICTIM_WB_COALESCE_EN.
package victim_wb_pkg;

  localparam int s_offset      = 5;
  localparam int s_index       = 4;
  localparam int s_tag         = 32 - s_offset - s_index;
  localparam int s_line        = 8 * (2 ** s_offset);
  localparam int depth_default = 4;
  localparam int key_w         = s_tag + s_index;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    POP   = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic                valid;
    logic [s_tag-1:0]    tag;
    logic [s_index-1:0]  index;
    logic [s_line-1:0]   data;
  } wb_entry_t;

  // Line-aligned physical address of a {tag,index} pair.
  function automatic logic [31:0] wb_addr(input logic [s_tag-1:0]   tag,
                                          input logic [s_index-1:0] index);
    return {tag, index, {s_offset{1'b0}}};
  endfunction

endpackage

// File: rtl/victim_wb_cam.sv
// Combinational {tag,index} match across the buffer ring. Scans from the head
// (oldest) towards the tail so the last match found is the youngest one.
module victim_wb_cam
  import victim_wb_pkg::*;
#(
  parameter int depth = depth_default,
  parameter int ptr_w = $clog2(depth)
) (
  input  logic [depth-1:0] valid,
  input  logic [key_w-1:0] keys [depth],
  input  logic [ptr_w-1:0] head,
  input  logic [key_w-1:0] key,
  output logic             hit,
  output logic [depth-1:0] onehot
);

  logic [ptr_w-1:0] idx_s;

  // Age-ordered scan: a younger matching slot replaces any older pick.
  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    idx_s  = head;
    for (int k = 0; k < depth; k++) begin
      idx_s = head + ptr_w'(k);
      if (valid[idx_s] && (keys[idx_s] == key)) begin
        hit           = 1'b1;
        onehot        = '0;
        onehot[idx_s] = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/victim_wb_buffer.sv
// Writeback buffer draining dirty victim lines to pmem, one line at a time,
// with a CAM so read misses can forward a still-queued line.
// Optional: define VICTIM_WB_COALESCE_EN to merge a push into a queued entry
// with the same {tag,index} (never into the head once its write has started).
module victim_wb_buffer
  import victim_wb_pkg::*;
#(
  parameter int depth = depth_default
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [s_tag-1:0]    push_tag,
  input  logic [s_index-1:0]  push_index,
  input  logic [s_line-1:0]   push_data,
  input  logic [31:0]         lookup_addr,
  output logic                lookup_hit,
  output logic [s_line-1:0]   lookup_data,
  output logic                pmem_write,
  output logic [31:0]         pmem_address,
  output logic [s_line-1:0]   pmem_wdata,
  input  logic                pmem_resp,
  output logic                empty
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  wb_state_t         state_r, state_next_s;
  wb_entry_t         entry_r [depth];
  logic [ptr_w-1:0]  head_r, tail_r;
  logic [cnt_w-1:0]  count_r, count_next_s;

  logic [depth-1:0]  valid_s, head_oh_s, look_valid_s, look_oh_s;
  logic [key_w-1:0]  key_s [depth];
  logic              pop_s, push_alloc_s, look_hit_s;
  logic              unused_s;

  // Byte offset within the line plays no part in line matching.
  assign unused_s = ^lookup_addr[s_offset-1:0];

  assign pop_s = (state_r == POP);

  // Flatten entry state into CAM-friendly vectors and a one-hot head marker.
  always_comb begin
    valid_s   = '0;
    head_oh_s = '0;
    for (int i = 0; i < depth; i++) begin
      valid_s[i] = entry_r[i].valid;
      key_s[i]   = {entry_r[i].tag, entry_r[i].index};
    end
    head_oh_s[head_r] = 1'b1;
  end

  // The head line is already in pmem once POP is reached, so stop forwarding it.
  always_comb begin
    look_valid_s = valid_s;
    if (pop_s) begin
      look_valid_s = valid_s & ~head_oh_s;
    end else begin
      look_valid_s = valid_s;
    end
  end

  victim_wb_cam #(.depth(depth), .ptr_w(ptr_w)) u_lookup_cam (
    .valid  (look_valid_s),
    .keys   (key_s),
    .head   (head_r),
    .key    (lookup_addr[31:s_offset]),
    .hit    (look_hit_s),
    .onehot (look_oh_s)
  );

  // One-hot AND-OR mux of the youngest matching line.
  always_comb begin
    lookup_data = '0;
    for (int i = 0; i < depth; i++) begin
      if (look_oh_s[i]) begin
        lookup_data = lookup_data | entry_r[i].data;
      end else begin
        lookup_data = lookup_data;
      end
    end
  end

  assign lookup_hit = look_hit_s;

`ifdef VICTIM_WB_COALESCE_EN
  logic [depth-1:0] coal_valid_s, coal_oh_s;
  logic             coal_hit_s, push_coal_s;

  // Merge candidates: the head only while its write has not yet started.
  always_comb begin
    coal_valid_s = valid_s;
    if (state_r == IDLE) begin
      coal_valid_s = valid_s;
    end else begin
      coal_valid_s = valid_s & ~head_oh_s;
    end
  end

  victim_wb_cam #(.depth(depth), .ptr_w(ptr_w)) u_coal_cam (
    .valid  (coal_valid_s),
    .keys   (key_s),
    .head   (head_r),
    .key    ({push_tag, push_index}),
    .hit    (coal_hit_s),
    .onehot (coal_oh_s)
  );

  assign push_ready   = coal_hit_s || (count_r != full_cnt) || pop_s;
  assign push_coal_s  = push_valid && coal_hit_s;
  assign push_alloc_s = push_valid && !coal_hit_s && ((count_r != full_cnt) || pop_s);
`else
  // A pop in progress frees the head slot, so a full buffer can still take a push.
  assign push_ready   = (count_r != full_cnt) || pop_s;
  assign push_alloc_s = push_valid && push_ready;
`endif

  // Occupancy after this cycle's allocation and pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_alloc_s, pop_s})
      2'b10:   count_next_s = count_r + cnt_w'(1);
      2'b01:   count_next_s = count_r - cnt_w'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Drain FSM: one pmem write per queued line, dead POP cycle between lines.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != '0) state_next_s = WRITE;
        else               state_next_s = IDLE;
      end
      WRITE: begin
        if (pmem_resp) state_next_s = POP;
        else           state_next_s = WRITE;
      end
      POP: begin
        if (count_next_s != '0) state_next_s = WRITE;
        else                    state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Ring pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (pop_s)        head_r <= head_r + ptr_w'(1);
      if (push_alloc_s) tail_r <= tail_r + ptr_w'(1);
      count_r <= count_next_s;
    end
  end

  // Entry storage; the pop clear comes first so a full-buffer push into the
  // freed head slot wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      if (pop_s) entry_r[head_r].valid <= 1'b0;
      if (push_alloc_s) begin
        entry_r[tail_r] <= '{valid: 1'b1, tag: push_tag, index: push_index, data: push_data};
      end
`ifdef VICTIM_WB_COALESCE_EN
      for (int i = 0; i < depth; i++) begin
        if (push_coal_s && coal_oh_s[i]) entry_r[i].data <= push_data;
      end
`endif
    end
  end

  assign pmem_write   = (state_r == WRITE);
  assign pmem_address = wb_addr(entry_r[head_r].tag, entry_r[head_r].index);
  assign pmem_wdata   = entry_r[head_r].data;
  assign empty        = (count_r == '0) && (state_r == IDLE);

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Directed bench for victim_wb_buffer (depth 4). Honours VICTIM_WB_COALESCE_EN
// for the duplicate-push expectations.
module tb_victim_wb_buffer;
  import victim_wb_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               push_valid;
  logic               push_ready;
  logic [s_tag-1:0]   push_tag;
  logic [s_index-1:0] push_index;
  logic [s_line-1:0]  push_data;
  logic [31:0]        lookup_addr;
  logic               lookup_hit;
  logic [s_line-1:0]  lookup_data;
  logic               pmem_write;
  logic [31:0]        pmem_address;
  logic [s_line-1:0]  pmem_wdata;
  logic               pmem_resp;
  logic               empty;

  int total = 0;
  int bad   = 0;

  victim_wb_buffer dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_tag(push_tag), .push_index(push_index), .push_data(push_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] mk(input int n);
    logic [31:0] w;
    w = 32'hA500_0000 | n;
    return {8{w}};
  endfunction

  function automatic logic [31:0] la(input logic [s_tag-1:0] t, input logic [s_index-1:0] i);
    return {t, i, 5'b00000};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_push(input logic [s_tag-1:0] t, input logic [s_index-1:0] i, input int n);
    push_valid = 1'b1;
    push_tag   = t;
    push_index = i;
    push_data  = mk(n);
  endtask

  // Wait (bounded) for a write, check it, answer it; returns in the POP cycle.
  task automatic serve(input string tag, input logic [31:0] a, input logic [255:0] d);
    int n;
    n = 0;
    while (pmem_write !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_wr"}, 256'(pmem_write), 256'(1'b1));
    chk({tag, "_addr"}, 256'(pmem_address), 256'(a));
    chk({tag, "_data"}, pmem_wdata, d);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk({tag, "_popdead"}, 256'(pmem_write), 256'(1'b0));
  endtask

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_tag = '0; push_index = '0; push_data = '0;
    lookup_addr = 32'h0; pmem_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 256'(push_ready), 256'(1'b1));
    chk("rst_empty", 256'(empty), 256'(1'b1));
    chk("rst_pwrite", 256'(pmem_write), 256'(1'b0));
    chk("rst_hit", 256'(lookup_hit), 256'(1'b0));

    // Single line: {23'h1A2B3, 4'h5, 5'b0} = 0x034566A0.
    drive_push(23'h1A2B3, 4'h5, 100);
    tick();
    push_valid = 1'b0;
    chk("s1_idle_pw", 256'(pmem_write), 256'(1'b0));
    chk("s1_not_empty", 256'(empty), 256'(1'b0));
    tick();
    chk("s1_pw", 256'(pmem_write), 256'(1'b1));
    chk("s1_addr", 256'(pmem_address), 256'(32'h034566A0));
    chk("s1_data", pmem_wdata, mk(100));
    tick(); tick();
    chk("s1_hold", 256'(pmem_address), 256'(32'h034566A0));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("s1_pop_pw", 256'(pmem_write), 256'(1'b0));
    chk("s1_pop_empty", 256'(empty), 256'(1'b0));
    tick();
    chk("s1_empty", 256'(empty), 256'(1'b1));

    // Fill to depth, hold pmem off, then push-while-pop across pointer wrap.
    for (int n = 1; n <= 4; n++) begin
      drive_push(23'h100 + 23'(n), 4'(n), n);
      tick();
    end
    drive_push(23'h105, 4'(5), 5);
    #1;
    chk("full_ready", 256'(push_ready), 256'(1'b0));
    tick();
    chk("full_held", 256'(push_ready), 256'(1'b0));
    chk("full_head", 256'(pmem_address), 256'(la(23'h101, 4'(1))));
    for (int n = 5; n <= 8; n++) begin
      drive_push(23'h100 + 23'(n), 4'(n), n);
      #1;
      chk("wrap_full", 256'(push_ready), 256'(1'b0));
      serve("wrap", la(23'h100 + 23'(n - 4), 4'(n - 4)), mk(n - 4));
      #1;
      chk("pop_ready", 256'(push_ready), 256'(1'b1));
      tick();
      push_valid = 1'b0;
      #1;
      chk("stay_full", 256'(push_ready), 256'(1'b0));
    end
    for (int n = 5; n <= 8; n++) begin
      serve("drain", la(23'h100 + 23'(n), 4'(n)), mk(n));
    end
    tick();
    chk("drain_empty", 256'(empty), 256'(1'b1));

    // Lookup forwarding.
    drive_push(23'h7C, 4'h2, 200);
    lookup_addr = {23'h7C, 4'h2, 5'd7};
    #1;
    chk("lk_same_cycle", 256'(lookup_hit), 256'(1'b0));
    tick();
    push_valid = 1'b0;
    #1;
    chk("lk_hit_idle", 256'(lookup_hit), 256'(1'b1));
    chk("lk_data_idle", lookup_data, mk(200));
    lookup_addr = {23'h7C, 4'h3, 5'd0};
    #1;
    chk("lk_miss", 256'(lookup_hit), 256'(1'b0));
    lookup_addr = {23'h7C, 4'h2, 5'd0};
    tick();
    chk("lk_write", 256'(pmem_write), 256'(1'b1));
    chk("lk_hit_write", 256'(lookup_hit), 256'(1'b1));
    chk("lk_data_write", lookup_data, mk(200));
    serve("lk", la(23'h7C, 4'h2), mk(200));
    tick();
    chk("lk_gone", 256'(lookup_hit), 256'(1'b0));

    // Duplicate {tag,index} queued behind a busy head.
    drive_push(23'h2F, 4'h4, 300);
    tick();
    drive_push(23'h3A, 4'h6, 301);
    tick();
    drive_push(23'h3A, 4'h6, 302);
    tick();
    push_valid = 1'b0;
    lookup_addr = la(23'h3A, 4'h6);
    #1;
    chk("dup_hit", 256'(lookup_hit), 256'(1'b1));
    chk("dup_young", lookup_data, mk(302));
    serve("dupF", la(23'h2F, 4'h4), mk(300));
`ifdef VICTIM_WB_COALESCE_EN
    serve("dupC", la(23'h3A, 4'h6), mk(302));
`else
    serve("dupA", la(23'h3A, 4'h6), mk(301));
    serve("dupB", la(23'h3A, 4'h6), mk(302));
`endif
    tick();
    chk("dup_empty", 256'(empty), 256'(1'b1));

    // Reset during WRITE with three queued.
    for (int n = 0; n < 3; n++) begin
      drive_push(23'h40 + 23'(n), 4'(n), 400 + n);
      tick();
    end
    push_valid = 1'b0;
    chk("rw_pw", 256'(pmem_write), 256'(1'b1));
    #1;
    rst = 1'b1;
    #1;
    chk("rw_pw_drop", 256'(pmem_write), 256'(1'b0));
    chk("rw_empty", 256'(empty), 256'(1'b1));
    chk("rw_ready", 256'(push_ready), 256'(1'b1));
    tick();
    rst = 1'b0;
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("late_pw", 256'(pmem_write), 256'(1'b0));
    chk("late_empty", 256'(empty), 256'(1'b1));
    lookup_addr = la(23'h40, 4'(0));
    tick();
    chk("late_pw2", 256'(pmem_write), 256'(1'b0));
    chk("late_hit", 256'(lookup_hit), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
